// File: rtl/fp_to_int.sv
// fp_to_int: multi-cycle FP-to-integer converter for FCVT.{W,WU,L,LU}.{S,D}.
// Alignment uses a 1-bit/cycle shifter, so latency follows the operand exponent.
module fp_to_int #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_fmt,
    input  logic                  in_out_fmt,
    input  logic [2:0]            in_rm,
    output logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [4:0]            out_flag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_SHIFT,
        S_ROUND,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Latched request
    logic [63:0] op_q, op_d;
    logic        dbl_q, dbl_d;
    logic        uns_q, uns_d;
    logic        o64_q, o64_d;
    logic [2:0]  rm_q, rm_d;

    // Unpacked / aligning operand
    logic        sign_q, sign_d;
    logic        nan_q, nan_d;
    logic        big_q, big_d;
    logic        left_q, left_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] mag_q, mag_d;
    logic        g_q, g_d;
    logic        s_q, s_d;

    // Rounded result and output registers
    logic [63:0] res_q, res_d;
    logic [4:0]  flag_q, flag_d;
    logic [63:0] out_data_q, out_data_d;
    logic [4:0]  out_flag_q, out_flag_d;
    logic        out_valid_q, out_valid_d;

    // Unpack combinational signals
    logic               u_sign, u_nan, u_big, u_left, u_s;
    logic [5:0]         u_cnt;
    logic [64:0]        u_mag;
    logic               exp_zero, exp_max, frac_nz, box_bad;
    logic signed [12:0] u_e, u_lim;
    logic [52:0]        u_m;

    // Round combinational signals
    logic        r_inc, r_ovf, r_nv, r_pos, r_nx;
    logic [64:0] r_mag, r_half;
    logic [63:0] r_val, r_res;

    assign out_ready = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_flag  = out_flag_q;

    always_comb begin
        u_sign   = 1'b0;
        u_nan    = 1'b0;
        u_big    = 1'b0;
        u_left   = 1'b0;
        u_s      = 1'b0;
        u_cnt    = '0;
        u_mag    = '0;
        exp_zero = 1'b0;
        exp_max  = 1'b0;
        frac_nz  = 1'b0;
        box_bad  = 1'b0;
        u_e      = '0;
        u_m      = '0;
        if (dbl_q) begin
            u_sign   = op_q[63];
            exp_zero = (op_q[62:52] == '0);
            exp_max  = (op_q[62:52] == '1);
            frac_nz  = |op_q[51:0];
            u_e      = $signed({2'b00, op_q[62:52]}) - 13'sd1023;
            u_m      = {1'b1, op_q[51:0]};
        end else begin
            u_sign   = op_q[31];
            exp_zero = (op_q[30:23] == '0);
            exp_max  = (op_q[30:23] == '1);
            frac_nz  = |op_q[22:0];
            box_bad  = (op_q[63:32] != '1);
            u_e      = $signed({5'b00000, op_q[30:23]}) - 13'sd127;
            u_m      = {1'b1, op_q[22:0], 29'b0};
        end
        u_lim = o64_q ? 13'sd64 : 13'sd32;
        // Infinity lands in the e >= N branch since its exponent exceeds 64.
        if (box_bad || (exp_max && frac_nz)) begin
            u_nan = 1'b1;
        end else if (exp_zero) begin
            u_s = frac_nz;
        end else if (u_e >= u_lim) begin
            u_big = 1'b1;
        end else if (u_e < -13'sd1) begin
            u_s = 1'b1;
        end else if (u_e >= 13'sd52) begin
            u_left = 1'b1;
            u_cnt  = 6'(u_e - 13'sd52);
            u_mag  = {12'b0, u_m};
        end else begin
            u_cnt = 6'(13'sd52 - u_e);
            u_mag = {12'b0, u_m};
        end
    end

    always_comb begin
        case (rm_q)
            3'b000:  r_inc = g_q & (mag_q[0] | s_q);
            3'b010:  r_inc = (g_q | s_q) & sign_q;
            3'b011:  r_inc = (g_q | s_q) & ~sign_q;
            3'b100:  r_inc = g_q;
            default: r_inc = 1'b0;
        endcase
        r_mag  = mag_q + {64'b0, r_inc};
        r_half = o64_q ? {1'b0, 1'b1, 63'b0} : {33'b0, 1'b1, 31'b0};
        if (uns_q) begin
            r_ovf = sign_q ? (r_mag != '0) : (r_mag >= {r_half[63:0], 1'b0});
        end else begin
            r_ovf = sign_q ? (r_mag > r_half) : (r_mag >= r_half);
        end
        r_nv  = nan_q | big_q | r_ovf;
        r_pos = nan_q | ~sign_q;
        if (r_nv) begin
            if (uns_q) begin
                r_val = r_pos ? '1 : '0;
            end else begin
                r_val = r_pos ? (r_half[63:0] - 64'd1) : (~r_half[63:0] + 64'd1);
            end
        end else begin
            r_val = sign_q ? (~r_mag[63:0] + 64'd1) : r_mag[63:0];
        end
        r_res = o64_q ? r_val : {{32{r_val[31]}}, r_val[31:0]};
        r_nx  = (g_q | s_q) & ~r_nv;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid) state_d = S_UNPACK;
            S_UNPACK: state_d = (u_cnt == '0) ? S_ROUND : S_SHIFT;
            S_SHIFT:  if (cnt_q == 6'd1) state_d = S_ROUND;
            S_ROUND:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d        = op_q;
        dbl_d       = dbl_q;
        uns_d       = uns_q;
        o64_d       = o64_q;
        rm_d        = rm_q;
        sign_d      = sign_q;
        nan_d       = nan_q;
        big_d       = big_q;
        left_d      = left_q;
        cnt_d       = cnt_q;
        mag_d       = mag_q;
        g_d         = g_q;
        s_d         = s_q;
        res_d       = res_q;
        flag_d      = flag_q;
        out_data_d  = out_data_q;
        out_flag_d  = out_flag_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d  = in_data;
                    dbl_d = in_fmt[1];
                    uns_d = in_fmt[0];
                    o64_d = in_out_fmt;
                    rm_d  = in_rm;
                end
            end
            S_UNPACK: begin
                sign_d = u_sign;
                nan_d  = u_nan;
                big_d  = u_big;
                left_d = u_left;
                cnt_d  = u_cnt;
                mag_d  = u_mag;
                g_d    = 1'b0;
                s_d    = u_s;
            end
            S_SHIFT: begin
                cnt_d = cnt_q - 6'd1;
                if (left_q) begin
                    mag_d = mag_q << 1;
                end else begin
                    mag_d = mag_q >> 1;
                    g_d   = mag_q[0];
                    s_d   = s_q | g_q;
                end
            end
            S_ROUND: begin
                res_d  = r_res;
                flag_d = {r_nv, 3'b000, r_nx};
            end
            S_DONE: begin
                out_data_d  = res_q;
                out_flag_d  = flag_q;
                out_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            dbl_q       <= 1'b0;
            uns_q       <= 1'b0;
            o64_q       <= 1'b0;
            rm_q        <= '0;
            sign_q      <= 1'b0;
            nan_q       <= 1'b0;
            big_q       <= 1'b0;
            left_q      <= 1'b0;
            cnt_q       <= '0;
            mag_q       <= '0;
            g_q         <= 1'b0;
            s_q         <= 1'b0;
            res_q       <= '0;
            flag_q      <= '0;
            out_data_q  <= '0;
            out_flag_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dbl_q       <= dbl_d;
            uns_q       <= uns_d;
            o64_q       <= o64_d;
            rm_q        <= rm_d;
            sign_q      <= sign_d;
            nan_q       <= nan_d;
            big_q       <= big_d;
            left_q      <= left_d;
            cnt_q       <= cnt_d;
            mag_q       <= mag_d;
            g_q         <= g_d;
            s_q         <= s_d;
            res_q       <= res_d;
            flag_q      <= flag_d;
            out_data_q  <= out_data_d;
            out_flag_q  <= out_flag_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fp_to_int.sv
// Bench for fp_to_int: exact fixed-point reference model, queue scoreboard,
// directed corner cases plus randomized operands.
module tb_fp_to_int;

    logic        in_clk     = 1'b0;
    logic        in_rst_n   = 1'b0;
    logic        in_valid   = 1'b0;
    logic [63:0] in_data    = '0;
    logic [1:0]  in_fmt     = '0;
    logic        in_out_fmt = 1'b0;
    logic [2:0]  in_rm      = '0;
    logic        out_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic [4:0]  out_flag;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  flag;
        logic [7:0]  lat;
    } exp_t;

    typedef struct packed {
        exp_t        e;
        logic [63:0] t;
    } pend_t;

    pend_t       q[$];
    pend_t       cur;
    logic [63:0] exp_hold_data = '0;
    logic [4:0]  exp_hold_flag = '0;
    logic [63:0] last_accept   = '0;

    fp_to_int #(.DATA_WIDTH(64)) dut (
        .in_clk    (in_clk),
        .in_rst_n  (in_rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_fmt    (in_fmt),
        .in_out_fmt(in_out_fmt),
        .in_rm     (in_rm),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_flag  (out_flag)
    );

    always #5 in_clk = ~in_clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    endfunction

    // Exact value m * 2^(e-52) held as 128.128 fixed point; rounding and range
    // decided on the integer/fraction pair.
    function automatic exp_t model(input logic [63:0] d, input logic [1:0] f,
                                   input logic o64, input logic [2:0] rm);
        exp_t         r;
        logic         neg, nan, inf, tiny, up, ok, pos;
        int           e, n, sh;
        logic [52:0]  m;
        logic [255:0] sc;
        logic [127:0] ip, fr, half, rr;
        logic [63:0]  v;
        n = o64 ? 64 : 32;
        neg = 1'b0; nan = 1'b0; inf = 1'b0; tiny = 1'b0; e = 0; m = '0;
        if (f[1]) begin
            neg = d[63];
            if (d[62:52] == 11'h7FF) begin nan = (d[51:0] != 0); inf = ~nan; end
            else if (d[62:52] == 11'h000) tiny = (d[51:0] != 0);
            else begin e = int'(d[62:52]) - 1023; m = {1'b1, d[51:0]}; end
        end else if (d[63:32] != 32'hFFFFFFFF) begin
            nan = 1'b1;
        end else begin
            neg = d[31];
            if (d[30:23] == 8'hFF) begin nan = (d[22:0] != 0); inf = ~nan; end
            else if (d[30:23] == 8'h00) tiny = (d[22:0] != 0);
            else begin e = int'(d[30:23]) - 127; m = {1'b1, d[22:0], 29'b0}; end
        end
        half = 128'd1 << 127;
        ip = '0; fr = '0;
        if (tiny || (m != 0 && e < -76)) fr = 128'd1;
        else if (m != 0 && e < 64) begin
            sc = 256'(m) << (e + 76);
            ip = sc[255:128];
            fr = sc[127:0];
        end
        case (rm)
            3'd0:    up = (fr > half) || (fr == half && ip[0]);
            3'd2:    up = neg && (fr != 0);
            3'd3:    up = !neg && (fr != 0);
            3'd4:    up = (fr >= half);
            default: up = 1'b0;
        endcase
        rr = ip + 128'(up);
        if (nan || inf || (m != 0 && e >= 64)) ok = 1'b0;
        else if (f[0]) ok = neg ? (rr == 0) : (rr < (128'd1 << n));
        else ok = neg ? (rr <= (128'd1 << (n - 1))) : (rr < (128'd1 << (n - 1)));
        pos = nan || !neg;
        if (ok) v = neg ? 64'(-rr) : rr[63:0];
        else if (f[0]) v = pos ? '1 : '0;
        else v = pos ? ((64'd1 << (n - 1)) - 64'd1) : -(64'd1 << (n - 1));
        if (n == 32) v = {{32{v[31]}}, v[31:0]};
        sh = 0;
        if (!nan && !inf && m != 0 && e >= -1 && e < n) sh = (e < 52) ? 52 - e : e - 52;
        r.data = v;
        r.flag = {!ok, 3'b000, ok && (fr != 0)};
        r.lat  = 8'(3 + sh);
        return r;
    endfunction

    function automatic logic [63:0] rand_op(input logic dbl);
        logic [63:0] v;
        logic [51:0] msk;
        int          e, k;
        v   = {$urandom, $urandom};
        msk = '1;
        k   = int'($urandom_range(0, 15));
        e   = int'($urandom_range(0, 70)) - 5;
        if (k == 4) e = 30 + int'($urandom_range(0, 2)) + 32 * int'($urandom_range(0, 1));
        if (dbl) begin
            v[62:52] = 11'(1023 + e);
            if (k == 0) v[62:52] = '0;
            if (k == 1) v[62:52] = '1;
            if ((k == 0 || k == 1) && $urandom_range(0, 1) == 1) v[51:0] = '0;
            if (k == 2 || k == 3) v[51:0] = v[51:0] & (msk << $urandom_range(0, 52));
            if (k == 4) v[51:0] = msk << $urandom_range(0, 52);
        end else begin
            if (k != 5) v[63:32] = '1;
            v[30:23] = 8'(127 + e);
            if (k == 0) v[30:23] = '0;
            if (k == 1) v[30:23] = '1;
            if ((k == 0 || k == 1) && $urandom_range(0, 1) == 1) v[22:0] = '0;
            if (k == 2 || k == 3) v[22:0] = v[22:0] & 23'(msk << $urandom_range(0, 23));
            if (k == 4) v[22:0] = 23'(msk << $urandom_range(0, 23));
        end
        return v;
    endfunction

    // Busy cycles carry junk requests that the DUT must ignore.
    task automatic issue(input logic [63:0] d, input logic [1:0] f, input logic o, input logic [2:0] r);
        int guard;
        guard = 0;
        @(negedge in_clk);
        while (!out_ready && guard < 100) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = {$urandom, $urandom};
            in_fmt     = 2'($urandom);
            in_out_fmt = 1'($urandom);
            in_rm      = 3'($urandom);
            @(negedge in_clk);
            guard++;
        end
        if (!out_ready) begin
            chk("ready_timeout", 64'(out_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        in_data = d; in_fmt = f; in_out_fmt = o; in_rm = r; in_valid = 1'b1;
        @(posedge in_clk);
        q.push_back({model(d, f, o, r), 64'($time)});
        last_accept = 64'($time);
        #1;
        in_valid   = 1'b0;
        in_data    = {$urandom, $urandom};
        in_fmt     = 2'($urandom);
        in_out_fmt = 1'($urandom);
        in_rm      = 3'($urandom);
    endtask

    always @(negedge in_clk) begin
        if (!in_rst_n) begin
            exp_hold_data = '0;
            exp_hold_flag = '0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 64'(out_valid), 64'd0);
            end else begin
                cur = q.pop_front();
                chk("data", out_data, cur.e.data);
                chk("flag", 64'(out_flag), 64'(cur.e.flag));
                chk("latency", ($time - cur.t - 64'd5) / 64'd10, 64'(cur.e.lat));
                exp_hold_data = cur.e.data;
                exp_hold_flag = cur.e.flag;
            end
        end else begin
            chk("hold_data", out_data, exp_hold_data);
            chk("hold_flag", 64'(out_flag), 64'(exp_hold_flag));
        end
    end

    initial begin
        exp_t        p;
        logic [63:0] t1;
        int          guard;

        #12;
        chk("rst_ready", 64'(out_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_flag", 64'(out_flag), 64'd0);
        #10 in_rst_n = 1'b1;

        p = model(64'h400C000000000000, 2'b10, 1'b1, 3'd0);
        chk("pin_3p5_data", p.data, 64'd4);
        chk("pin_3p5_flag", 64'(p.flag), 64'd1);
        chk("pin_3p5_lat", 64'(p.lat), 64'd54);
        p = model(64'hFFFFFFFF_BFC00000, 2'b00, 1'b0, 3'd1);
        chk("pin_m1p5_data", p.data, 64'hFFFFFFFFFFFFFFFF);
        chk("pin_m1p5_flag", 64'(p.flag), 64'd1);
        p = model(64'h00000000_BFC00000, 2'b00, 1'b0, 3'd1);
        chk("pin_unboxed_data", p.data, 64'h000000007FFFFFFF);
        chk("pin_unboxed_flag", 64'(p.flag), 64'h10);
        p = model(64'h7FF8000000000000, 2'b10, 1'b0, 3'd0);
        chk("pin_qnan_data", p.data, 64'h000000007FFFFFFF);
        chk("pin_qnan_lat", 64'(p.lat), 64'd3);
        p = model(64'h7FF8000000000000, 2'b11, 1'b1, 3'd0);
        chk("pin_qnan_lu", p.data, 64'hFFFFFFFFFFFFFFFF);
        p = model(64'hBFD3333333333333, 2'b11, 1'b0, 3'd2);
        chk("pin_m0p3_rdn", {p.data[58:0], p.flag}, 64'h10);
        p = model(64'h41DFFFFFFFE00000, 2'b10, 1'b0, 3'd0);
        chk("pin_max_rne_flag", 64'(p.flag), 64'h10);
        p = model(64'h41DFFFFFFFE00000, 2'b10, 1'b0, 3'd1);
        chk("pin_max_rtz_data", p.data, 64'h000000007FFFFFFF);
        p = model(64'h3FF0000000000000, 2'b10, 1'b1, 3'd0);
        chk("pin_one_lat", 64'(p.lat), 64'd55);

        issue(64'h400C000000000000, 2'b10, 1'b1, 3'd0);
        issue(64'hFFFFFFFF_BFC00000, 2'b00, 1'b0, 3'd1);
        issue(64'h00000000_BFC00000, 2'b00, 1'b0, 3'd1);
        issue(64'hBFD3333333333333, 2'b11, 1'b0, 3'd1);
        issue(64'hBFD3333333333333, 2'b11, 1'b0, 3'd2);
        issue(64'h41DFFFFFFFE00000, 2'b10, 1'b0, 3'd0);
        issue(64'h41DFFFFFFFE00000, 2'b10, 1'b0, 3'd1);
        issue(64'hBFE0000000000000, 2'b10, 1'b1, 3'd0);
        issue(64'hC3E0000000000000, 2'b10, 1'b1, 3'd1);
        issue(64'h7FF8000000000000, 2'b11, 1'b1, 3'd0);
        issue(64'h7FF8000000000000, 2'b10, 1'b0, 3'd0);
        t1 = last_accept;
        issue(64'h7FF8000000000000, 2'b10, 1'b0, 3'd0);
        chk("issue_interval", last_accept - t1, 64'd40);

        issue(64'h3FF0000000000000, 2'b10, 1'b1, 3'd0);
        repeat (10) @(negedge in_clk);
        #2 in_rst_n = 1'b0;
        q.delete();
        #1;
        chk("abort_ready", 64'(out_ready), 64'd1);
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_data", out_data, 64'd0);
        chk("abort_flag", 64'(out_flag), 64'd0);
        @(negedge in_clk);
        #2 in_rst_n = 1'b1;
        repeat (70) @(negedge in_clk);
        issue(64'h3FF0000000000000, 2'b10, 1'b1, 3'd0);

        for (int i = 0; i < 400; i++) begin
            logic dbl;
            dbl = 1'($urandom_range(0, 1));
            issue(rand_op(dbl), {dbl, 1'($urandom_range(0, 1))}, 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)));
        end

        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            @(negedge in_clk);
            guard++;
        end
        chk("drain", 64'(q.size()), 64'd0);
        repeat (2) @(negedge in_clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
